// File: rtl/key_attempt_sched.sv
// key_attempt_sched: arbitrates two requesters onto one serial key-detector
// FSM. Each granted attempt clears the FSM, shifts the key in MSB first,
// samples the unlock output and reports pass/fail. Repeated failures lock
// a requester out for a fixed number of cycles.

// Per-requester fail counter and lockout timer.
module key_attempt_lock #(
    parameter int MAX_FAIL = 3,
    parameter int LOCK_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic resp_evt,   // high in the RESP cycle of this requester's attempt
    input  logic pass,
    output logic locked
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYC + 1);

    logic [FW-1:0] fail_cnt;
    logic [TW-1:0] timer;

    // Lockout runs on its own; a result can only arrive while unlocked since
    // a locked requester is never granted. The timer hits 0 on the edge that
    // drops locked, so locked is high for exactly LOCK_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
            timer    <= '0;
            locked   <= 1'b0;
        end else if (locked) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1))
                locked <= 1'b0;
        end else if (resp_evt) begin
            if (pass) begin
                fail_cnt <= '0;
            end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                fail_cnt <= '0;
                locked   <= 1'b1;
                timer    <= TW'(LOCK_CYC);
            end else begin
                fail_cnt <= fail_cnt + FW'(1);
            end
        end
    end
endmodule

module key_attempt_sched #(
    parameter int KEY_W    = 5,
    parameter int MAX_FAIL = 3,
    parameter int LOCK_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [KEY_W-1:0] req_key0,
    input  logic [KEY_W-1:0] req_key1,
    output logic [1:0]       req_ready,
    output logic             fsm_clr,
    output logic             fsm_x,
    input  logic             fsm_out,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             resp_pass,
    output logic [1:0]       locked
);
    localparam int CW = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SAMPLE, RESP} state_t;

    state_t           state, state_nxt;
    logic [KEY_W-1:0] key_q, key_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic             id_q, id_nxt;
    logic             last_q, last_nxt;   // last granted requester
    logic [1:0]       ready_nxt;
    logic             clr_nxt, x_nxt, rv_nxt, rid_nxt, rpass_nxt;
    logic [1:0]       elig;
    logic             gnt;

    assign elig = req_valid & ~locked;

    // Next state and next registered outputs. Outputs are computed one cycle
    // ahead so req_ready/fsm_clr appear together in the CLEAR cycle and each
    // fsm_x bit lands in its SHIFT cycle.
    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        cnt_nxt   = cnt_q;
        id_nxt    = id_q;
        last_nxt  = last_q;
        ready_nxt = 2'b00;
        clr_nxt   = 1'b0;
        x_nxt     = 1'b0;
        rv_nxt    = 1'b0;
        rid_nxt   = resp_id;
        rpass_nxt = resp_pass;
        gnt       = 1'b0;
        case (state)
            IDLE: begin
                if (elig != 2'b00) begin
                    gnt       = (elig == 2'b11) ? ~last_q : elig[1];
                    ready_nxt = gnt ? 2'b10 : 2'b01;
                    key_nxt   = gnt ? req_key1 : req_key0;
                    id_nxt    = gnt;
                    last_nxt  = gnt;
                    clr_nxt   = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                x_nxt     = key_q[KEY_W-1];
                key_nxt   = key_q << 1;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == CW'(KEY_W - 1)) begin
                    state_nxt = SAMPLE;
                end else begin
                    x_nxt   = key_q[KEY_W-1];
                    key_nxt = key_q << 1;
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                rv_nxt    = 1'b1;
                rid_nxt   = id_q;
                rpass_nxt = fsm_out;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any attempt in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            req_ready  <= 2'b00;
            fsm_clr    <= 1'b0;
            fsm_x      <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_pass  <= 1'b0;
        end else begin
            state      <= state_nxt;
            key_q      <= key_nxt;
            cnt_q      <= cnt_nxt;
            id_q       <= id_nxt;
            last_q     <= last_nxt;
            req_ready  <= ready_nxt;
            fsm_clr    <= clr_nxt;
            fsm_x      <= x_nxt;
            resp_valid <= rv_nxt;
            resp_id    <= rid_nxt;
            resp_pass  <= rpass_nxt;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_lock
        key_attempt_lock #(.MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC)) u_lock (
            .clk      (clk),
            .rst_n    (rst_n),
            .resp_evt (resp_valid && (resp_id == 1'(i))),
            .pass     (resp_pass),
            .locked   (locked[i])
        );
    end
endmodule

// File: tb/tb_key_attempt_sched.sv
// Directed bench for key_attempt_sched with a behavioural key-detector FSM
// (unlock key 11110, blackhole after five zeros) and a result scoreboard.
module tb_key_attempt_sched;
    localparam int KEY_W = 5;
    localparam int LAT   = KEY_W + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [KEY_W-1:0] req_key0, req_key1;
    logic [1:0]       req_ready;
    logic             fsm_clr, fsm_x, fsm_out;
    logic             resp_valid, resp_id, resp_pass;
    logic [1:0]       locked;

    key_attempt_sched #(.KEY_W(KEY_W), .MAX_FAIL(3), .LOCK_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_key0(req_key0), .req_key1(req_key1), .req_ready(req_ready),
        .fsm_clr(fsm_clr), .fsm_x(fsm_x), .fsm_out(fsm_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_pass(resp_pass),
        .locked(locked)
    );

    always #5 clk = ~clk;

    // Golden key-detector FSM: Moore unlock after exactly 11110 since clear,
    // sticky blackhole after five zeros, left only by a clear.
    logic [4:0] m_hist = '0;
    logic [2:0] m_cnt  = '0;
    logic       m_bh   = 1'b0;
    always @(posedge clk) begin
        if (fsm_clr) begin
            m_hist <= '0;
            m_cnt  <= '0;
            m_bh   <= 1'b0;
        end else begin
            m_hist <= {m_hist[3:0], fsm_x};
            if (m_cnt != 3'd7) m_cnt <= m_cnt + 3'd1;
            if ({m_hist[3:0], fsm_x} == 5'b00000 && m_cnt >= 3'd4) m_bh <= 1'b1;
        end
    end
    assign fsm_out = !m_bh && (m_cnt == 3'd5) && (m_hist == 5'b11110);

    typedef struct {logic id; logic pass; int t;} exp_t;
    exp_t sb[$];
    int   n_cmp = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle; sample at the falling edge and retire any result.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (resp_valid !== 1'b0) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL resp_unexpected observed=%0h expected=0", resp_valid);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_id", resp_id, e.id);
                chk("resp_pass", resp_pass, e.pass);
                chk("resp_latency", cyc - e.t, LAT);
            end
        end
    endtask

    task automatic push(input logic id, input logic pass);
        exp_t e;
        e.id = id; e.pass = pass; e.t = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 30; n++) begin
            tick();
            if (req_ready != 2'b00) return;
        end
        n_cmp++;
        assert (req_ready != 2'b00) else begin
            n_err++;
            $error("FAIL ready_timeout observed=%0h expected=nonzero", req_ready);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (sb.size() == 0) return;
            tick();
        end
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL resp_timeout observed=%0d expected=0 pending", sb.size());
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_clr"}, fsm_clr, 0);
        chk({tag, "_x"}, fsm_x, 0);
        chk({tag, "_rv"}, resp_valid, 0);
        chk({tag, "_rid"}, resp_id, 0);
        chk({tag, "_rpass"}, resp_pass, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    task automatic reset_dut(input string tag);
        rst_n = 1'b0;
        #1;
        chk_idle_outs(tag);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic attempt(input logic id, input logic [KEY_W-1:0] key, input logic pass);
        if (id) req_key1 = key; else req_key0 = key;
        req_valid[id] = 1'b1;
        wait_ready();
        chk("att_ready", req_ready, id ? 2'b10 : 2'b01);
        push(id, pass);
        req_valid[id] = 1'b0;
        drain();
    endtask

    initial begin
        logic [KEY_W-1:0] good, kb;
        logic [1:0]       exp_g;
        int lock_cnt, saw0, served;
        good = 5'b11110;
        req_valid = 2'b00; req_key0 = '0; req_key1 = '0;
        reset_dut("rst0");

        // Single request: handshake, clear, serial bits, result.
        req_key0 = good; req_valid = 2'b01;
        wait_ready();
        chk("s1_ready", req_ready, 2'b01);
        chk("s1_clr", fsm_clr, 1);
        chk("s1_clr_x", fsm_x, 0);
        push(0, 1);
        req_valid = 2'b00;
        req_key0 = 5'b00000;   // must not disturb the captured key
        kb = good;
        for (int k = 0; k < KEY_W; k++) begin
            tick();
            chk("s1_shift_x", fsm_x, kb[KEY_W-1-k]);
            chk("s1_shift_clr", fsm_clr, 0);
            chk("s1_shift_ready", req_ready, 0);
        end
        tick();
        chk("s1_sample_x", fsm_x, 0);
        drain();

        // Both requesting continuously: grants alternate from requester 0.
        reset_dut("rst1");
        req_key0 = good; req_key1 = good; req_valid = 2'b11;
        exp_g = 2'b01;
        for (int g = 0; g < 4; g++) begin
            wait_ready();
            chk("rr_grant", req_ready, exp_g);
            push(exp_g[1], 1);
            if (g == 3) req_valid = 2'b00;
            exp_g = {exp_g[0], exp_g[1]};
        end
        drain();

        // Three fails lock requester 0 for 16 cycles; requester 1 still served.
        for (int f = 0; f < 3; f++) begin
            chk("lk_pre_locked", locked, 0);
            attempt(0, 5'b00001, 0);
        end
        req_key0 = 5'b00001; req_key1 = good; req_valid = 2'b11;
        lock_cnt = 0; saw0 = 0; served = 0;
        tick();
        chk("lk_rise", locked, 2'b01);
        for (int n = 0; n < 40; n++) begin
            if (locked[0]) lock_cnt++;
            if (req_ready[0]) saw0++;
            if (req_ready[1]) begin
                push(1, 1);
                req_valid[1] = 1'b0;
                served++;
            end
            if (!locked[0]) begin
                req_valid[0] = 1'b0;
                break;
            end
            tick();
        end
        chk("lk_cycles", lock_cnt, 16);
        chk("lk_no_ack0", saw0, 0);
        chk("lk_served1", served, 1);
        drain();

        // Blackhole key then good key: clear recovers the detector.
        attempt(0, 5'b00000, 0);
        attempt(0, good, 1);

        // Reset during SHIFT cycle 2 abandons the attempt silently.
        req_key0 = good; req_valid = 2'b01;
        wait_ready();
        push(0, 1);
        req_valid = 2'b00;
        repeat (3) tick();
        chk("mid_x_before", fsm_x, 1);
        reset_dut("rst_mid");
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("mid_no_ready", req_ready, 0);
        end
        attempt(0, good, 1);

        // fail, fail, pass, fail, fail: the pass clears the count.
        reset_dut("rst2");
        attempt(0, 5'b00001, 0);
        attempt(0, 5'b00001, 0);
        attempt(0, good, 1);
        attempt(0, 5'b00001, 0);
        attempt(0, 5'b00001, 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("ffpff_unlocked", locked, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
